// File: rtl/cv32e40p_apu_core_pkg.sv
// ============================================================================
// Module   : cv32e40p_apu_core_pkg
// Brief    : Shared APU constants and the buffered response record.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cv32e40p_apu_core_pkg;

    localparam int APU_NUSFLAGS_CPU = 5;
    localparam int APU_RESP_DEPTH   = 2;

    typedef struct packed {
        logic [31:0]                 rdata;
        logic [APU_NUSFLAGS_CPU-1:0] rflags;
    } apu_resp_t;

endpackage

`default_nettype wire

// File: rtl/cv32e40p_apu_credit_ctr.sv
// ============================================================================
// Module   : cv32e40p_apu_credit_ctr
// Brief    : In-flight op counter, issue credit and unexpected-response error.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cv32e40p_apu_credit_ctr #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             issue_i,
    input  logic             rvalid_i,
    input  logic [CNT_W-1:0] count_i,
    output logic [CNT_W-1:0] inflight_o,
    output logic             issue_allow_o,
    output logic             unexp_err_o
);

    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

    logic [CNT_W-1:0] inflight;
    logic             retire;
    logic             unexpected;

    // A response with nothing outstanding does not retire anything.
    assign retire     = rvalid_i & (inflight != '0);
    assign unexpected = rvalid_i & (inflight == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            inflight    <= '0;
            unexp_err_o <= 1'b0;
        end else begin
            case ({issue_i, retire})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            if (unexpected) begin
                unexp_err_o <= 1'b1;
            end
        end
    end

    assign inflight_o    = inflight;
    assign issue_allow_o = ({1'b0, inflight} + {1'b0, count_i}) < DEPTH_C;

endmodule

`default_nettype wire

// File: rtl/cv32e40p_apu_resp_buffer.sv
// ============================================================================
// Module   : cv32e40p_apu_resp_buffer
// Brief    : Non-back-pressurable APU response FIFO with credits and fflags.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cv32e40p_apu_resp_buffer
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int DEPTH   = APU_RESP_DEPTH,
    parameter int FLAGS_W = APU_NUSFLAGS_CPU
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               apu_req_i,
    input  logic               apu_gnt_i,
    input  logic               apu_rvalid_i,
    input  logic [31:0]        apu_rdata_i,
    input  logic [FLAGS_W-1:0] apu_rflags_i,
    output logic               issue_allow_o,
    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic [31:0]        wb_rdata_o,
    output logic [FLAGS_W-1:0] wb_rflags_o,
    input  logic               fflags_clr_i,
    output logic [FLAGS_W-1:0] fflags_o,
    output logic               idle_o,
    output logic               err_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    apu_resp_t        mem [DEPTH];
    apu_resp_t        head;
    apu_resp_t        resp_in;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] inflight;
    logic [FLAGS_W-1:0] fflags;
    logic             issue;
    logic             pop;
    logic             push;
    logic             overflow;
    logic             ovf_err;
    logic             unexp_err;
    logic             allow;

    assign resp_in  = '{rdata: apu_rdata_i, rflags: apu_rflags_i};
    assign issue    = apu_req_i & apu_gnt_i;
    assign pop      = wb_valid_o & wb_ready_i;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push     = apu_rvalid_i & ((count != DEPTH_C) | pop);
    assign overflow = apu_rvalid_i & ~push;

    assign rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
    assign wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;

    cv32e40p_apu_credit_ctr #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_credit_ctr (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .issue_i       (issue),
        .rvalid_i      (apu_rvalid_i),
        .count_i       (count),
        .inflight_o    (inflight),
        .issue_allow_o (allow),
        .unexp_err_o   (unexp_err)
    );

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= resp_in;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            head    <= '0;
            fflags  <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // The head register must show the next entry the cycle after a
            // push or pop; when the FIFO empties out it keeps its old value.
            if (push && ((count == '0) || (pop && (count == ONE_C)))) begin
                head <= resp_in;
            end else if (pop && (count > ONE_C)) begin
                head <= mem[rd_ptr_nxt];
            end
            fflags <= (fflags_clr_i ? '0 : fflags) | (pop ? head.rflags : '0);
            if (overflow) begin
                ovf_err <= 1'b1;
            end
        end
    end

    assign issue_allow_o = allow;
    assign wb_valid_o    = (count != '0);
    assign wb_rdata_o    = head.rdata;
    assign wb_rflags_o   = head.rflags;
    assign fflags_o      = fflags;
    assign idle_o        = (inflight == '0) && (count == '0);
    assign err_o         = ovf_err | unexp_err;

endmodule

`default_nettype wire
